// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker.
package sysid_checker_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LAT_W   = 2;
    localparam int unsigned STALL_W = 16;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [DATA_W-1:0] DEFAULT_EXPECTED_TS = 32'd1412490851;

    typedef enum logic [2:0] {
        IDLE,
        RD_ID,
        LAT_ID,
        RD_TS,
        LAT_TS,
        FIN
    } state_t;

endpackage

// File: rtl/sysid_checker.sv
// Avalon-MM read-only master: reads the system-ID and build-timestamp words
// and reports whether they match the expected hardware image.
// Optional stall watchdog enabled by defining SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [DATA_W-1:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [DATA_W-1:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned       READ_LATENCY   = 0,
    parameter int unsigned       TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              id_ok,
    output logic              ts_ok,
    output logic [DATA_W-1:0] id_value,
    output logic [DATA_W-1:0] ts_value,
    output logic              timeout
);

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               id_cap_q, id_cap_d;
    logic               ts_cap_q, ts_cap_d;
    logic [DATA_W-1:0]  id_value_d, ts_value_d;
    logic               id_ok_d, ts_ok_d, pass_d, timeout_d;
    logic               avm_read_d, avm_address_d, busy_d, done_d;

`ifdef SYSID_CHECKER_TIMEOUT_EN
    logic [STALL_W-1:0] stall_q, stall_d;
`else
    logic               unused_timeout_cfg;
    assign unused_timeout_cfg = ^STALL_W'(TIMEOUT_CYCLES);
`endif

    // Next-state, capture and registered-output decode
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        id_cap_d   = id_cap_q;
        ts_cap_d   = ts_cap_q;
        id_value_d = id_value;
        ts_value_d = ts_value;
        id_ok_d    = id_ok;
        ts_ok_d    = ts_ok;
        pass_d     = pass;
        timeout_d  = timeout;
`ifdef SYSID_CHECKER_TIMEOUT_EN
        stall_d    = '0;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RD_ID;
                    id_cap_d   = 1'b0;
                    ts_cap_d   = 1'b0;
                    id_value_d = '0;
                    ts_value_d = '0;
                    id_ok_d    = 1'b0;
                    ts_ok_d    = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        id_value_d = avm_readdata;
                        id_cap_d   = 1'b1;
                        state_d    = RD_TS;
                    end else begin
                        lat_d   = LAT_W'(READ_LATENCY);
                        state_d = LAT_ID;
                    end
                end
            end
            LAT_ID: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    id_value_d = avm_readdata;
                    id_cap_d   = 1'b1;
                    state_d    = RD_TS;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    if (READ_LATENCY == 0) begin
                        ts_value_d = avm_readdata;
                        ts_cap_d   = 1'b1;
                        state_d    = FIN;
                    end else begin
                        lat_d   = LAT_W'(READ_LATENCY);
                        state_d = LAT_TS;
                    end
                end
            end
            LAT_TS: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    ts_value_d = avm_readdata;
                    ts_cap_d   = 1'b1;
                    state_d    = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef SYSID_CHECKER_TIMEOUT_EN
        // Abort a read stalled for TIMEOUT_CYCLES; counter restarts on accept
        if ((state_q == RD_ID || state_q == RD_TS) && avm_waitrequest) begin
            if (stall_q == STALL_W'(TIMEOUT_CYCLES)) begin
                state_d   = FIN;
                timeout_d = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
`endif

        avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
        avm_address_d = (state_d == RD_TS || state_d == LAT_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        busy_d        = state_d inside {RD_ID, LAT_ID, RD_TS, LAT_TS};
        done_d        = (state_d == FIN);

        // Verdict only on entry to FIN; uncaptured words never count as matching
        if (state_d == FIN) begin
            id_ok_d = id_cap_d && (id_value_d == EXPECTED_ID);
            ts_ok_d = ts_cap_d && (ts_value_d == EXPECTED_TS);
            pass_d  = id_ok_d && ts_ok_d && !timeout_d;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            id_cap_q    <= 1'b0;
            ts_cap_q    <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SYSID_CHECKER_TIMEOUT_EN
            stall_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            id_cap_q    <= id_cap_d;
            ts_cap_q    <= ts_cap_d;
            id_value    <= id_value_d;
            ts_value    <= ts_value_d;
            id_ok       <= id_ok_d;
            ts_ok       <= ts_ok_d;
            pass        <= pass_d;
            timeout     <= timeout_d;
            avm_read    <= avm_read_d;
            avm_address <= avm_address_d;
            busy        <= busy_d;
            done        <= done_d;
`ifdef SYSID_CHECKER_TIMEOUT_EN
            stall_q     <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (read latency 0 and 2), each with
// its own Avalon slave model; expectations come from the documented timing.
module tb_sysid_checker;
    import sysid_checker_pkg::*;

    localparam int unsigned TO_CYC = 5;
    localparam logic [31:0] EXP_ID = DEFAULT_EXPECTED_ID;
    localparam logic [31:0] EXP_TS = DEFAULT_EXPECTED_TS;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_s         [2];
    logic        avm_address     [2];
    logic        avm_read        [2];
    logic        avm_waitrequest [2];
    logic [31:0] avm_readdata    [2];
    logic        busy            [2];
    logic        done            [2];
    logic        pass            [2];
    logic        id_ok           [2];
    logic        ts_ok           [2];
    logic [31:0] id_value        [2];
    logic [31:0] ts_value        [2];
    logic        timeout         [2];

    // Slave model state
    logic [31:0] mem     [2][2];
    int          nstall;
    int          stalled [2][2];
    int          pend    [2];
    logic        paddr   [2];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO_CYC)) dut0 (
        .clock(clock), .reset(reset), .start(start_s[0]),
        .avm_address(avm_address[0]), .avm_read(avm_read[0]),
        .avm_waitrequest(avm_waitrequest[0]), .avm_readdata(avm_readdata[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
        .id_value(id_value[0]), .ts_value(ts_value[0]), .timeout(timeout[0])
    );

    sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO_CYC)) dut1 (
        .clock(clock), .reset(reset), .start(start_s[1]),
        .avm_address(avm_address[1]), .avm_read(avm_read[1]),
        .avm_waitrequest(avm_waitrequest[1]), .avm_readdata(avm_readdata[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
        .id_value(id_value[1]), .ts_value(ts_value[1]), .timeout(timeout[1])
    );

    function automatic int lat(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic slave_clear(input int ns);
        nstall = ns;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0;
            stalled[i][0] = 0;
            stalled[i][1] = 0;
        end
    endtask

    // One clock edge; afterwards update the slave models and check stall hold
    task automatic step();
        logic rd_b [2];
        logic ad_b [2];
        logic wr_b [2];
        logic rst_b;
        rst_b = reset;
        for (int i = 0; i < 2; i++) begin
            rd_b[i] = avm_read[i];
            ad_b[i] = avm_address[i];
            wr_b[i] = avm_waitrequest[i];
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_b && rd_b[i] === 1'b1 && wr_b[i] === 1'b1 && timeout[i] !== 1'b1) begin
                checks++;
                if (avm_read[i] !== 1'b1 || avm_address[i] !== ad_b[i]) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: read=%b addr=%b, required read=1 addr=%b",
                             i, avm_read[i], avm_address[i], ad_b[i]);
                end
            end
            if (!rst_b && rd_b[i] === 1'b1 && wr_b[i] === 1'b0 && lat(i) > 0) begin
                pend[i]  = lat(i);
                paddr[i] = ad_b[i];
            end else if (pend[i] > 0) begin
                pend[i]--;
            end
            if (avm_read[i] === 1'b1 && stalled[i][avm_address[i]] < nstall) begin
                avm_waitrequest[i] = 1'b1;
                stalled[i][avm_address[i]]++;
            end else begin
                avm_waitrequest[i] = 1'b0;
            end
            if (lat(i) == 0)
                avm_readdata[i] = (avm_read[i] === 1'b1 && !avm_waitrequest[i]) ? mem[i][avm_address[i]] : $urandom;
            else
                avm_readdata[i] = (pend[i] == 1) ? mem[i][paddr[i]] : $urandom;
        end
    endtask

    // Full check on both instances with ns stall cycles per read
    task automatic run_check(input int ns, input bit restart, input string tag);
        int  ed [2];
        int  dn [2];
        int  ts_lo, ts_hi;
        bit  exp_rd;
        logic [31:0] e_id, e_ts;
        slave_clear(ns);
        for (int i = 0; i < 2; i++) begin
            ed[i] = 3 + 2 * lat(i) + 2 * ns;
            dn[i] = 0;
            start_s[i] = 1'b1;
        end
        step();
        for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
        for (int c = 1; c <= ed[1] + 2; c++) begin
            for (int i = 0; i < 2; i++) begin
                ts_lo  = 2 + ns + lat(i);
                ts_hi  = 2 + 2 * ns + lat(i);
                exp_rd = (c <= 1 + ns) || (c >= ts_lo && c <= ts_hi);
                checks++;
                if (avm_read[i] !== exp_rd) begin
                    errors++;
                    $display("FAIL %s read dut%0d cyc%0d: got %b, required %b", tag, i, c, avm_read[i], exp_rd);
                end
                if (exp_rd) begin
                    checks++;
                    if (avm_address[i] !== (c >= ts_lo)) begin
                        errors++;
                        $display("FAIL %s addr dut%0d cyc%0d: got %b, required %b", tag, i, c, avm_address[i], c >= ts_lo);
                    end
                end
                checks++;
                if (busy[i] !== (c < ed[i]) || done[i] !== (c == ed[i])) begin
                    errors++;
                    $display("FAIL %s busy/done dut%0d cyc%0d: got %b/%b, required %b/%b",
                             tag, i, c, busy[i], done[i], c < ed[i], c == ed[i]);
                end
                if (done[i] === 1'b1) dn[i]++;
            end
            for (int i = 0; i < 2; i++) start_s[i] = restart && (c == 1 || c == 2);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            e_id = mem[i][0];
            e_ts = mem[i][1];
            checks++;
            if (dn[i] != 1) begin
                errors++;
                $display("FAIL %s done_count dut%0d: got %0d, required 1", tag, i, dn[i]);
            end
            checks++;
            if (id_value[i] !== e_id || ts_value[i] !== e_ts) begin
                errors++;
                $display("FAIL %s values dut%0d: got %h/%h, required %h/%h", tag, i, id_value[i], ts_value[i], e_id, e_ts);
            end
            checks++;
            if (id_ok[i] !== (e_id == EXP_ID) || ts_ok[i] !== (e_ts == EXP_TS) ||
                pass[i] !== (e_id == EXP_ID && e_ts == EXP_TS) || timeout[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s verdict dut%0d: id_ok=%b ts_ok=%b pass=%b timeout=%b, required %b %b %b 0",
                         tag, i, id_ok[i], ts_ok[i], pass[i], timeout[i],
                         e_id == EXP_ID, e_ts == EXP_TS, e_id == EXP_ID && e_ts == EXP_TS);
            end
        end
    endtask

    task automatic test_reset();
        logic [71:0] v;
        reset = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            v = {avm_address[i], avm_read[i], busy[i], done[i], pass[i], id_ok[i], ts_ok[i],
                 timeout[i], id_value[i], ts_value[i]};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h, required 0", i, v);
            end
        end
        reset = 1'b0;
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || avm_read[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle dut%0d: busy=%b done=%b read=%b, required 0 0 0", i, busy[i], done[i], avm_read[i]);
            end
        end
    endtask

    task automatic test_basic();
        mem[0][0] = EXP_ID;  mem[0][1] = EXP_TS;
        mem[1][0] = EXP_ID;  mem[1][1] = 32'h1234_5678;
        run_check(0, 1'b0, "basic");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            mem[i][0] = EXP_ID;
            mem[i][1] = EXP_TS;
        end
        run_check(4, 1'b0, "stall4");
    endtask

    task automatic test_restart_reset();
        logic [71:0] v;
        mem[0][0] = EXP_ID;       mem[0][1] = EXP_TS;
        mem[1][0] = 32'hdead_beef; mem[1][1] = EXP_TS;
        run_check(0, 1'b1, "restart");
        slave_clear(0);
        for (int i = 0; i < 2; i++) start_s[i] = 1'b1;
        step();
        for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            v = {avm_address[i], avm_read[i], busy[i], done[i], pass[i], id_ok[i], ts_ok[i],
                 timeout[i], id_value[i], ts_value[i]};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: got %h, required 0", i, v);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (done[i] !== 1'b0 || busy[i] !== 1'b0 || avm_read[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_quiet dut%0d: done=%b busy=%b read=%b, required 0 0 0",
                             i, done[i], busy[i], avm_read[i]);
                end
            end
        end
    endtask

    // Start held through FIN is ignored; the next cycle's start is taken
    task automatic test_back_to_back();
        int dn;
        int dc;
        slave_clear(0);
        mem[0][0] = EXP_ID;
        mem[0][1] = EXP_TS;
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        step();
        step();
        checks++;
        if (done[0] !== 1'b1 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first dut0: done=%b pass=%b, required 1 1", done[0], pass[0]);
        end
        start_s[0] = 1'b1;
        step();
        checks++;
        if (busy[0] !== 1'b0 || pass[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fin_start dut0: busy=%b pass=%b, required 0 1", busy[0], pass[0]);
        end
        mem[0][0] = EXP_ID ^ 32'h0000_0001;
        step();
        start_s[0] = 1'b0;
        checks++;
        if (busy[0] !== 1'b1 || pass[0] !== 1'b0 || id_ok[0] !== 1'b0 || id_value[0] !== 32'd0) begin
            errors++;
            $display("FAIL b2b_clear dut0: busy=%b pass=%b id_ok=%b id=%h, required 1 0 0 0",
                     busy[0], pass[0], id_ok[0], id_value[0]);
        end
        dn = 0;
        dc = 0;
        for (int c = 5; c <= 12; c++) begin
            if (done[0] === 1'b1) begin
                dn++;
                dc = c;
            end
            step();
        end
        checks++;
        if (dn != 1 || dc != 7) begin
            errors++;
            $display("FAIL b2b_done dut0: count=%0d cycle=%0d, required 1 at 7", dn, dc);
        end
        checks++;
        if (pass[0] !== 1'b0 || id_ok[0] !== 1'b0 || ts_ok[0] !== 1'b1 || id_value[0] !== (EXP_ID ^ 32'h1)) begin
            errors++;
            $display("FAIL b2b_verdict dut0: pass=%b id_ok=%b ts_ok=%b id=%h, required 0 0 1 %h",
                     pass[0], id_ok[0], ts_ok[0], id_value[0], EXP_ID ^ 32'h1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 2; i++) begin
                mem[i][0] = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
                mem[i][1] = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
            end
            run_check(int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

`ifdef SYSID_CHECKER_TIMEOUT_EN
    task automatic test_timeout();
        int rdc [2];
        int dn  [2];
        slave_clear(1000);
        for (int i = 0; i < 2; i++) begin
            mem[i][0] = EXP_ID;
            mem[i][1] = EXP_TS;
            rdc[i] = 0;
            dn[i]  = 0;
            start_s[i] = 1'b1;
        end
        step();
        for (int i = 0; i < 2; i++) start_s[i] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (avm_read[i] === 1'b1) rdc[i]++;
                if (done[i] === 1'b1) dn[i]++;
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dn[i] != 1 || rdc[i] < int'(TO_CYC) || rdc[i] > int'(TO_CYC) + 1) begin
                errors++;
                $display("FAIL timeout_timing dut%0d: done_count=%0d read_cycles=%0d, required 1 and %0d..%0d",
                         i, dn[i], rdc[i], TO_CYC, TO_CYC + 1);
            end
            checks++;
            if (timeout[i] !== 1'b1 || pass[i] !== 1'b0 || id_ok[i] !== 1'b0 || ts_ok[i] !== 1'b0 ||
                avm_read[i] !== 1'b0 || busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL timeout_verdict dut%0d: timeout=%b pass=%b id_ok=%b ts_ok=%b read=%b busy=%b, required 1 0 0 0 0 0",
                         i, timeout[i], pass[i], id_ok[i], ts_ok[i], avm_read[i], busy[i]);
            end
        end
    endtask
`else
    task automatic test_long_stall();
        for (int i = 0; i < 2; i++) begin
            mem[i][0] = EXP_ID;
            mem[i][1] = $urandom;
        end
        run_check(30, 1'b0, "long_stall");
    endtask
`endif

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i]         = 1'b0;
            avm_waitrequest[i] = 1'b0;
            avm_readdata[i]    = '0;
            mem[i][0]          = '0;
            mem[i][1]          = '0;
        end
        slave_clear(0);
        test_reset();
        test_basic();
        test_stall();
        test_restart_reset();
        test_back_to_back();
        test_random();
`ifdef SYSID_CHECKER_TIMEOUT_EN
        test_timeout();
`else
        test_long_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
